// File: rtl/archer_projectile_ctl.sv
// archer_projectile_ctl: spawns, moves and retires the archer's arrows, one
// motion step per frame_tick, feeding packed slot positions and active flags
// to the projectile draw stage.
// Optional build macro PROJ_HIT_EN adds boss collision inputs, boss_hit
// output and retire-on-hit; without it the block has no collision logic.
module archer_projectile_ctl #(
  parameter int unsigned PROJECTILE_COUNT = 4,
  parameter int unsigned PROJ_SPEED       = 4,
  parameter int unsigned COOLDOWN_FRAMES  = 20,
  parameter int unsigned MAX_RANGE        = 400,
  parameter int unsigned SPAWN_OFFSET     = 16,
  parameter int unsigned HOR_PIXELS       = 1024
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           frame_tick,
  input  logic                           fire,
  input  logic [11:0]                    pos_x_archer,
  input  logic [11:0]                    pos_y_archer,
  input  logic                           flip_hor_archer,
  input  logic [1:0]                     game_active,
  input  logic [1:0]                     char_class,
  input  logic                           alive,
  output logic [PROJECTILE_COUNT*12-1:0] pos_x_proj,
  output logic [PROJECTILE_COUNT*12-1:0] pos_y_proj,
  output logic [PROJECTILE_COUNT-1:0]    projectile_animated,
  output logic                           shot_fired
`ifdef PROJ_HIT_EN
  ,
  input  logic [11:0]                    boss_x,
  input  logic [11:0]                    boss_y,
  input  logic [7:0]                     boss_hw,
  input  logic [7:0]                     boss_hh,
  input  logic [0:0]                     boss_alive,
  output logic                           boss_hit
`endif
);

  localparam int unsigned CD_W = $clog2(COOLDOWN_FRAMES + 1);

  typedef enum logic {IDLE, FLYING} slot_state_t;

  slot_state_t       state_q [PROJECTILE_COUNT];
  logic [11:0]       x_q     [PROJECTILE_COUNT];
  logic [11:0]       y_q     [PROJECTILE_COUNT];
  logic              dir_q   [PROJECTILE_COUNT];
  logic [9:0]        dist_q  [PROJECTILE_COUNT];
  logic [CD_W-1:0]   cooldown_q;
  logic              fire_req_q;
  logic              fire_d_q;

  logic                        enable;
  logic                        fire_edge;
  logic                        any_idle;
  logic                        spawn_ok;
  logic [12:0]                 spawn_x;
  logic [PROJECTILE_COUNT-1:0] spawn_sel;
  logic [PROJECTILE_COUNT-1:0] retire;
  logic [11:0]                 x_step  [PROJECTILE_COUNT];
`ifdef PROJ_HIT_EN
  logic [PROJECTILE_COUNT-1:0] hit;
  logic [11:0]                 dx;
  logic [11:0]                 dy;
`endif

  assign enable    = (game_active != 2'd0) && (char_class == 2'd2) && alive;
  assign fire_edge = fire & ~fire_d_q;

  // Spawn x carries a 13th bit so a left-edge underflow wraps far above
  // HOR_PIXELS and is rejected by the same upper-bound test.
  always_comb begin
    if (flip_hor_archer)
      spawn_x = {1'b0, pos_x_archer} - 13'(SPAWN_OFFSET);
    else
      spawn_x = {1'b0, pos_x_archer} + 13'(SPAWN_OFFSET);
  end

  // Lowest-index idle slot as a one-hot select.
  always_comb begin
    spawn_sel = '0;
    any_idle  = 1'b0;
    for (int unsigned i = 0; i < PROJECTILE_COUNT; i++) begin
      if (state_q[i] == IDLE && !any_idle) begin
        spawn_sel[i] = 1'b1;
        any_idle     = 1'b1;
      end
    end
  end

  assign spawn_ok = frame_tick && enable && (fire_req_q | fire_edge) &&
                    (cooldown_q == '0) && any_idle &&
                    (spawn_x < 13'(HOR_PIXELS));

  // Per-slot next x and retire decision for the next motion step.
  always_comb begin
    for (int unsigned i = 0; i < PROJECTILE_COUNT; i++) begin
      retire[i] = 1'b0;
      x_step[i] = x_q[i];
      if ((11'(dist_q[i]) + 11'(PROJ_SPEED)) >= 11'(MAX_RANGE)) begin
        retire[i] = 1'b1;
      end else if (dir_q[i]) begin
        if (x_q[i] < 12'(PROJ_SPEED)) retire[i] = 1'b1;
        else                          x_step[i] = x_q[i] - 12'(PROJ_SPEED);
      end else begin
        if ((13'(x_q[i]) + 13'(PROJ_SPEED)) >= 13'(HOR_PIXELS)) retire[i] = 1'b1;
        else                                                  x_step[i] = x_q[i] + 12'(PROJ_SPEED);
      end
    end
  end

`ifdef PROJ_HIT_EN
  // Box overlap test against the boss for every flying slot.
  always_comb begin
    hit = '0;
    dx  = '0;
    dy  = '0;
    for (int unsigned i = 0; i < PROJECTILE_COUNT; i++) begin
      dx = (x_q[i] >= boss_x) ? (x_q[i] - boss_x) : (boss_x - x_q[i]);
      dy = (y_q[i] >= boss_y) ? (y_q[i] - boss_y) : (boss_y - y_q[i]);
      hit[i] = boss_alive[0] && (state_q[i] == FLYING) &&
               (dx < {4'd0, boss_hw}) && (dy < {4'd0, boss_hh});
    end
  end
`endif

  // Slot FSMs, fire capture, cooldown and shot pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < PROJECTILE_COUNT; i++) begin
        state_q[i] <= IDLE;
        x_q[i]     <= '0;
        y_q[i]     <= '0;
        dir_q[i]   <= 1'b0;
        dist_q[i]  <= '0;
      end
      cooldown_q <= '0;
      fire_req_q <= 1'b0;
      fire_d_q   <= 1'b0;
      shot_fired <= 1'b0;
`ifdef PROJ_HIT_EN
      boss_hit   <= 1'b0;
`endif
    end else begin
      fire_d_q   <= fire;
      shot_fired <= 1'b0;
`ifdef PROJ_HIT_EN
      boss_hit   <= 1'b0;
`endif
      if (!enable) begin
        for (int unsigned i = 0; i < PROJECTILE_COUNT; i++) state_q[i] <= IDLE;
        fire_req_q <= 1'b0;
        cooldown_q <= '0;
      end else if (frame_tick) begin
        fire_req_q <= 1'b0;
        if (spawn_ok) begin
          cooldown_q <= CD_W'(COOLDOWN_FRAMES);
          shot_fired <= 1'b1;
        end else if (cooldown_q != '0) begin
          cooldown_q <= cooldown_q - 1'b1;
        end
`ifdef PROJ_HIT_EN
        boss_hit <= |hit;
`endif
        for (int unsigned i = 0; i < PROJECTILE_COUNT; i++) begin
          if (spawn_ok && spawn_sel[i]) begin
            state_q[i] <= FLYING;
            x_q[i]     <= spawn_x[11:0];
            y_q[i]     <= pos_y_archer;
            dir_q[i]   <= flip_hor_archer;
            dist_q[i]  <= '0;
          end else if (state_q[i] == FLYING) begin
`ifdef PROJ_HIT_EN
            if (hit[i] || retire[i]) begin
`else
            if (retire[i]) begin
`endif
              state_q[i] <= IDLE;
            end else begin
              x_q[i]    <= x_step[i];
              dist_q[i] <= dist_q[i] + 10'(PROJ_SPEED);
            end
          end
        end
      end else if (fire_edge) begin
        fire_req_q <= 1'b1;
      end
    end
  end

  // Pack slot registers onto the draw-stage buses.
  always_comb begin
    pos_x_proj          = '0;
    pos_y_proj          = '0;
    projectile_animated = '0;
    for (int unsigned i = 0; i < PROJECTILE_COUNT; i++) begin
      pos_x_proj[i*12 +: 12] = x_q[i];
      pos_y_proj[i*12 +: 12] = y_q[i];
      projectile_animated[i] = (state_q[i] == FLYING);
    end
  end

endmodule

// File: tb/tb_archer_projectile_ctl.sv
// Self-checking bench for archer_projectile_ctl: behavioural slot model with
// a per-cycle compare, plus hand-computed literal checks along the scenario.
module tb_archer_projectile_ctl;
  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            frame_tick = 1'b0;
  logic            fire = 1'b0;
  logic [11:0]     pax = 12'd200;
  logic [11:0]     pay = 12'd300;
  logic            flip = 1'b0;
  logic [1:0]      game_active = 2'd1;
  logic [1:0]      char_class = 2'd2;
  logic            alive = 1'b1;
  logic [N*12-1:0] pos_x_proj;
  logic [N*12-1:0] pos_y_proj;
  logic [N-1:0]    projectile_animated;
  logic            shot_fired;
`ifdef PROJ_HIT_EN
  logic [11:0]     boss_x = '0;
  logic [11:0]     boss_y = '0;
  logic [7:0]      boss_hw = '0;
  logic [7:0]      boss_hh = '0;
  logic [0:0]      boss_alive = '0;
  logic            boss_hit;
`endif

  archer_projectile_ctl dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .fire(fire),
    .pos_x_archer(pax), .pos_y_archer(pay), .flip_hor_archer(flip),
    .game_active(game_active), .char_class(char_class), .alive(alive),
    .pos_x_proj(pos_x_proj), .pos_y_proj(pos_y_proj),
    .projectile_animated(projectile_animated), .shot_fired(shot_fired)
`ifdef PROJ_HIT_EN
    , .boss_x(boss_x), .boss_y(boss_y), .boss_hw(boss_hw), .boss_hh(boss_hh),
    .boss_alive(boss_alive), .boss_hit(boss_hit)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int m_x[N], m_y[N], m_dist[N];
  bit m_act[N], m_dir[N];
  int m_cd;
  bit m_req, m_fd, m_shot, m_hit;

  always @(posedge clk or negedge rst_n) begin
    bit fe, en;
    int slot, sx, dx, dy;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_x[i] = 0; m_y[i] = 0; m_dist[i] = 0; m_act[i] = 0; m_dir[i] = 0;
      end
      m_cd = 0; m_req = 0; m_fd = 0; m_shot = 0; m_hit = 0;
    end else begin
      fe = fire && !m_fd;
      m_fd = fire;
      en = (game_active != 0) && (char_class == 2) && alive;
      m_shot = 0;
      m_hit = 0;
      if (!en) begin
        for (int i = 0; i < N; i++) m_act[i] = 0;
        m_req = 0;
        m_cd = 0;
      end else if (frame_tick) begin
        slot = -1;
        if ((m_req || fe) && m_cd == 0)
          for (int i = N - 1; i >= 0; i--) if (!m_act[i]) slot = i;
        sx = flip ? int'(pax) - 16 : int'(pax) + 16;
        if (sx < 0 || sx >= 1024) slot = -1;
        for (int i = 0; i < N; i++) begin
          if (m_act[i]) begin
            dx = m_x[i] - 0; dy = 0;
`ifdef PROJ_HIT_EN
            dx = m_x[i] - int'(boss_x); if (dx < 0) dx = -dx;
            dy = m_y[i] - int'(boss_y); if (dy < 0) dy = -dy;
            if (boss_alive[0] && dx < int'(boss_hw) && dy < int'(boss_hh)) begin
              m_act[i] = 0;
              m_hit = 1;
            end else
`endif
            if (m_dist[i] + 4 >= 400 || (m_dir[i] && m_x[i] < 4) ||
                (!m_dir[i] && m_x[i] + 4 >= 1024)) begin
              m_act[i] = 0;
            end else begin
              m_x[i] = m_dir[i] ? m_x[i] - 4 : m_x[i] + 4;
              m_dist[i] += 4;
            end
          end
        end
        if (slot >= 0) begin
          m_act[slot] = 1; m_x[slot] = sx; m_y[slot] = int'(pay);
          m_dir[slot] = flip; m_dist[slot] = 0; m_cd = 20; m_shot = 1;
        end else if (m_cd > 0) begin
          m_cd--;
        end
        m_req = 0;
      end else if (fe) begin
        m_req = 1;
      end
    end
  end

  // Per-cycle compare of every output against the model
  always @(negedge clk) begin
    logic [N*12-1:0] ex, ey;
    logic [N-1:0] ea;
    bit eh;
    for (int i = 0; i < N; i++) begin
      ex[i*12 +: 12] = 12'(m_x[i]);
      ey[i*12 +: 12] = 12'(m_y[i]);
      ea[i] = m_act[i];
    end
    eh = 0;
`ifdef PROJ_HIT_EN
    eh = (boss_hit !== m_hit);
`endif
    checks++;
    if (pos_x_proj !== ex || pos_y_proj !== ey || projectile_animated !== ea ||
        shot_fired !== m_shot || eh) begin
      errors++;
      $display("FAIL model_cycle t=%0t anim=%b exp=%b x=%h exp=%h y=%h exp=%h shot=%b exp=%b",
               $time, projectile_animated, ea, pos_x_proj, ex, pos_y_proj, ey, shot_fired, m_shot);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int slot_x(input int i);
    return int'(pos_x_proj[i*12 +: 12]);
  endfunction

  task automatic tick();
    repeat (2) @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic press();
    @(negedge clk);
    fire = 1'b1;
    @(negedge clk);
    fire = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_anim", int'(projectile_animated), 0);
    chk("reset_x", int'(pos_x_proj), 0);
    chk("reset_shot", int'(shot_fired), 0);
    rst_n = 1'b1;

    // First shot, then three motion steps
    press(); tick();
    chk("spawn_anim", int'(projectile_animated), 1);
    chk("spawn_x", slot_x(0), 216);
    chk("spawn_y", int'(pos_y_proj[11:0]), 300);
    chk("spawn_shot", int'(shot_fired), 1);
    ticks(3);
    chk("move3_x", slot_x(0), 228);

    // Shot during cooldown is dropped; frame 21 is accepted
    ticks(1); press(); tick();
    chk("cooldown_drop_anim", int'(projectile_animated), 1);
    chk("cooldown_drop_shot", int'(shot_fired), 0);
    ticks(15); press(); tick();
    chk("frame21_anim", int'(projectile_animated), 3);
    chk("frame21_x1", slot_x(1), 216);
    chk("frame21_x0", slot_x(0), 300);

    // Fill every slot, then one more edge finds nothing free
    ticks(20); press(); tick();
    ticks(20); press(); tick();
    chk("full_anim", int'(projectile_animated), 15);
    ticks(20); press(); tick();
    chk("nofree_anim", int'(projectile_animated), 15);
    chk("nofree_shot", int'(shot_fired), 0);

    // Range limit: slot0 retires on its 100th motion tick
    ticks(15);
    chk("range99_x0", slot_x(0), 612);
    chk("range99_anim0", int'(projectile_animated[0]), 1);
    tick();
    chk("range100_anim", int'(projectile_animated), 14);
    chk("range100_x0_held", slot_x(0), 612);

    // Player death drops all flying slots next clock
    @(negedge clk); alive = 1'b0;
    @(negedge clk);
    chk("dead_anim", int'(projectile_animated), 0);
    chk("dead_x0_held", slot_x(0), 612);
    alive = 1'b1;

    // Asynchronous reset mid-flight
    press(); tick();
    chk("respawn_anim", int'(projectile_animated), 1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_anim", int'(projectile_animated), 0);
    chk("async_rst_x", int'(pos_x_proj), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Facing left near the left edge
    flip = 1'b1; pax = 12'd40;
    press(); tick();
    chk("left_spawn_x", slot_x(0), 24);
    ticks(6);
    chk("left_x0", slot_x(0), 0);
    chk("left_anim_at0", int'(projectile_animated), 1);
    tick();
    chk("left_retire_anim", int'(projectile_animated), 0);
    chk("left_no_wrap_x", slot_x(0), 0);

    // Off-screen spawn is suppressed without loading cooldown
    ticks(20);
    pax = 12'd10;
    press(); tick();
    chk("suppress_anim", int'(projectile_animated), 0);
    chk("suppress_shot", int'(shot_fired), 0);
    flip = 1'b0; pax = 12'd1000;
    press(); tick();
    chk("right_spawn_x", slot_x(0), 1016);
    chk("right_spawn_shot", int'(shot_fired), 1);
    tick();
    chk("right_x", slot_x(0), 1020);
    tick();
    chk("right_retire_anim", int'(projectile_animated), 0);

    // Edge coincident with frame_tick fires; held button never re-fires
    ticks(20);
    pax = 12'd200;
    @(negedge clk); fire = 1'b1; frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    chk("same_cycle_shot", int'(shot_fired), 1);
    ticks(21);
    chk("held_anim", int'(projectile_animated), 1);
    fire = 1'b0;

`ifdef PROJ_HIT_EN
    // Boss box over slot0 (x=300): slot0 retires, new shot takes slot1
    boss_x = 12'd300; boss_y = 12'd300; boss_hw = 8'd8; boss_hh = 8'd8;
    boss_alive = 1'b1;
    press(); tick();
    chk("hit_pulse", int'(boss_hit), 1);
    chk("hit_anim", int'(projectile_animated), 2);
    tick();
    chk("hit_pulse_end", int'(boss_hit), 0);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
